updown_counter: RTL



---
 rtl/updown_counter.sv | 80 ++++++++
 1 files changed

// File: rtl/updown_counter.sv
// Up/down counter with modulus, clamped synchronous load and an enable prescaler.
// Build option: define UPDOWN_COUNTER_SAT_EN to saturate at the range ends instead of wrapping.
module updown_counter #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH:0]   MODULUS  = '0,
    parameter int               PRESCALE = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] out_o,
    output logic             step_o,
    output logic             tc_o
);

    // MAX carried with one guard bit so MODULUS = 2^WIDTH still compares correctly
    localparam logic [WIDTH:0]   MAX_G = (MODULUS == '0) ? {1'b0, {WIDTH{1'b1}}}
                                                         : MODULUS - (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] MAX   = MAX_G[WIDTH-1:0];
    localparam int               PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] r_out;
    logic [PW-1:0]    r_pre;
    logic             r_step;
    logic             r_tc;

    logic             w_pre_last;
    logic             w_step;
    logic             w_bound;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load_val;

    assign w_pre_last = (r_pre == PRE_LAST);
    assign w_step     = en_i && w_pre_last;
    assign w_bound    = dir_i ? (r_out == MAX) : (r_out == '0);
    assign w_load_val = ({1'b0, load_val_i} > MAX_G) ? MAX : load_val_i;

    always_comb begin
        w_next = dir_i ? (r_out + WIDTH'(1)) : (r_out - WIDTH'(1));
        if (w_bound) begin
`ifdef UPDOWN_COUNTER_SAT_EN
            w_next = r_out;
`else
            w_next = dir_i ? '0 : MAX;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_out  <= '0;
            r_pre  <= '0;
            r_step <= 1'b0;
            r_tc   <= 1'b0;
        end else if (load_i) begin
            r_out  <= w_load_val;
            r_pre  <= '0;
            r_step <= 1'b0;
            r_tc   <= 1'b0;
        end else begin
            r_step <= w_step;
            r_tc   <= w_step && w_bound;
            if (en_i) begin
                r_pre <= w_pre_last ? '0 : r_pre + PW'(1);
            end
            if (w_step) begin
                r_out <= w_next;
            end
        end
    end

    assign out_o  = r_out;
    assign step_o = r_step;
    assign tc_o   = r_tc;

endmodule
